// File: rtl/proc_io_bridge.sv
// Peripheral-side IO responder: RX/TX stream FIFOs, status/control
// registers and synchronised general-purpose words on the core's IO port.
module proc_io_bridge #(
  parameter int NUBITS = 16,
  parameter int NUIOIN = 8,
  parameter int NUIOOU = 8,
  parameter int FDEPTH = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           req_in,
  input  logic [$clog2(NUIOIN)-1:0]      addr_in,
  output logic [NUBITS-1:0]              io_in,
  input  logic                           out_en,
  input  logic [$clog2(NUIOOU)-1:0]      addr_out,
  input  logic [NUBITS-1:0]              io_out,
  input  logic [NUBITS-1:0]              rx_data,
  input  logic                           rx_valid,
  output logic                           rx_ready,
  output logic [NUBITS-1:0]              tx_data,
  output logic                           tx_valid,
  input  logic                           tx_ready,
  input  logic [NUBITS*(NUIOIN-2)-1:0]   gpi,
  output logic [NUBITS*(NUIOOU-2)-1:0]   gpo
);

  localparam int AIW = $clog2(NUIOIN);
  localparam int AOW = $clog2(NUIOOU);
  localparam int AW  = $clog2(FDEPTH);
  localparam int CW  = AW + 1;
  localparam int GIW = NUBITS * (NUIOIN - 2);

  logic [NUBITS-1:0] rx_mem [FDEPTH];
  logic [AW-1:0]     rx_rptr, rx_wptr;
  logic [CW-1:0]     rx_cnt, rx_cnt_nx;
  logic [NUBITS-1:0] tx_mem [FDEPTH];
  logic [AW-1:0]     tx_rptr, tx_wptr;
  logic [CW-1:0]     tx_cnt;
  logic              rx_uf, tx_of;
  logic [GIW-1:0]    gpi_s1, gpi_s2;
  logic [NUBITS-1:0] status, gpi_sel;

  logic rd_rx, rd_st, wr_tx, wr_ctl;
  logic rx_push, rx_pop, rx_flush, rx_full;
  logic tx_push, tx_pop, tx_flush, tx_full;
  logic uf_evt, of_evt;

  assign rd_rx  = req_in && (addr_in == AIW'(0));
  assign rd_st  = req_in && (addr_in == AIW'(1));
  assign wr_tx  = out_en && (addr_out == AOW'(0));
  assign wr_ctl = out_en && (addr_out == AOW'(1));

  assign rx_full  = (rx_cnt == CW'(FDEPTH));
  assign rx_push  = rx_valid && rx_ready;
  assign rx_pop   = rd_rx && (rx_cnt != '0);
  assign rx_flush = wr_ctl && io_out[0];
  assign uf_evt   = rd_rx && (rx_cnt == '0);

  assign tx_full  = (tx_cnt == CW'(FDEPTH));
  assign tx_valid = (tx_cnt != '0);
  assign tx_data  = tx_mem[tx_rptr];
  assign tx_push  = wr_tx && !tx_full;
  assign tx_pop   = tx_valid && tx_ready;
  assign tx_flush = wr_ctl && io_out[1];
  assign of_evt   = wr_tx && tx_full;

  always_comb begin
    rx_cnt_nx = rx_cnt;
    if (rx_flush)
      rx_cnt_nx = '0;
    else if (rx_push && !rx_pop)
      rx_cnt_nx = rx_cnt + 1'b1;
    else if (!rx_push && rx_pop)
      rx_cnt_nx = rx_cnt - 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FDEPTH; i++)
        rx_mem[i] <= '0;
      rx_rptr  <= '0;
      rx_wptr  <= '0;
      rx_cnt   <= '0;
      rx_ready <= 1'b0;
    end else begin
      rx_cnt   <= rx_cnt_nx;
      rx_ready <= (rx_cnt_nx != CW'(FDEPTH));
      if (rx_flush) begin
        rx_rptr <= '0;
        rx_wptr <= '0;
      end else begin
        if (rx_push) begin
          rx_mem[rx_wptr] <= rx_data;
          rx_wptr <= rx_wptr + 1'b1;
        end
        if (rx_pop)
          rx_rptr <= rx_rptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FDEPTH; i++)
        tx_mem[i] <= '0;
      tx_rptr <= '0;
      tx_wptr <= '0;
      tx_cnt  <= '0;
    end else if (tx_flush) begin
      tx_rptr <= '0;
      tx_wptr <= '0;
      tx_cnt  <= '0;
    end else begin
      if (tx_push) begin
        tx_mem[tx_wptr] <= io_out;
        tx_wptr <= tx_wptr + 1'b1;
      end
      if (tx_pop)
        tx_rptr <= tx_rptr + 1'b1;
      if (tx_push && !tx_pop)
        tx_cnt <= tx_cnt + 1'b1;
      else if (!tx_push && tx_pop)
        tx_cnt <= tx_cnt - 1'b1;
    end
  end

  // A fresh event on the clearing edge keeps its sticky bit set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_uf <= 1'b0;
      tx_of <= 1'b0;
    end else begin
      rx_uf <= uf_evt || (rx_uf && !rd_st);
      tx_of <= of_evt || (tx_of && !rd_st);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gpi_s1 <= '0;
      gpi_s2 <= '0;
    end else begin
      gpi_s1 <= gpi;
      gpi_s2 <= gpi_s1;
    end
  end

  always_comb begin
    status       = '0;
    status[0]    = (rx_cnt == '0);
    status[1]    = rx_full;
    status[2]    = !tx_valid;
    status[3]    = tx_full;
    status[4]    = rx_uf;
    status[5]    = tx_of;
    status[15:8] = 8'(rx_cnt);
  end

  always_comb begin
    gpi_sel = '0;
    for (int k = 2; k < NUIOIN; k++)
      if (addr_in == AIW'(k))
        gpi_sel = gpi_s2[(k-2)*NUBITS +: NUBITS];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      io_in <= '0;
    end else if (req_in) begin
      if (rd_rx)
        io_in <= rx_pop ? rx_mem[rx_rptr] : '0;
      else if (rd_st)
        io_in <= status;
      else
        io_in <= gpi_sel;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gpo <= '0;
    end else if (out_en) begin
      for (int k = 2; k < NUIOOU; k++)
        if (addr_out == AOW'(k))
          gpo[(k-2)*NUBITS +: NUBITS] <= io_out;
    end
  end

endmodule

// File: tb/tb_proc_io_bridge.sv
// Directed bench for proc_io_bridge: reset, RX/TX FIFOs, sticky flags,
// flush, gpio synchroniser and asynchronous reset mid-burst.
module tb_proc_io_bridge;

  localparam int NB = 16;
  localparam int NI = 8;
  localparam int NO = 8;
  localparam int FD = 8;

  logic                 clk;
  logic                 rst;
  logic                 req_in;
  logic [2:0]           addr_in;
  logic [NB-1:0]        io_in;
  logic                 out_en;
  logic [2:0]           addr_out;
  logic [NB-1:0]        io_out;
  logic [NB-1:0]        rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic [NB-1:0]        tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic [NB*(NI-2)-1:0] gpi;
  logic [NB*(NO-2)-1:0] gpo;

  int checks = 0;
  int errors = 0;

  proc_io_bridge #(
    .NUBITS(NB), .NUIOIN(NI), .NUIOOU(NO), .FDEPTH(FD)
  ) dut (
    .clk(clk), .rst(rst),
    .req_in(req_in), .addr_in(addr_in), .io_in(io_in),
    .out_en(out_en), .addr_out(addr_out), .io_out(io_out),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .gpi(gpi), .gpo(gpo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [2:0] a);
    req_in  = 1'b1;
    addr_in = a;
    step();
    req_in  = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [NB-1:0] d);
    out_en   = 1'b1;
    addr_out = a;
    io_out   = d;
    step();
    out_en   = 1'b0;
  endtask

  initial begin
    rst = 1'b0; req_in = 1'b0; addr_in = '0;
    out_en = 1'b0; addr_out = '0; io_out = '0;
    rx_data = '0; rx_valid = 1'b0; tx_ready = 1'b0; gpi = '0;

    step(); step();
    chk("rst_io_in", 32'(io_in), 32'h0);
    chk("rst_rx_ready", 32'(rx_ready), 32'h0);
    chk("rst_tx_valid", 32'(tx_valid), 32'h0);
    chk("rst_tx_data", 32'(tx_data), 32'h0);
    chk("rst_gpo", 32'(gpo[31:0]), 32'h0);

    rst = 1'b1;
    step();
    chk("rel_rx_ready", 32'(rx_ready), 32'h1);
    rd(3'd1);
    chk("status_idle", 32'(io_in), 32'h0005);
    chk("idle_tx_valid", 32'(tx_valid), 32'h0);
    chk("idle_gpo", 32'(gpo[95:64]), 32'h0);

    // RX stream and underflow
    rx_valid = 1'b1;
    rx_data = 16'h1111; step();
    rx_data = 16'h2222; step();
    rx_data = 16'h3333; step();
    rx_valid = 1'b0;
    rd(3'd0); chk("rx_pop0", 32'(io_in), 32'h1111);
    rd(3'd0); chk("rx_pop1", 32'(io_in), 32'h2222);
    rd(3'd0); chk("rx_pop2", 32'(io_in), 32'h3333);
    rd(3'd0); chk("rx_underflow_data", 32'(io_in), 32'h0);
    rd(3'd1); chk("status_uf", 32'(io_in), 32'h0015);
    rd(3'd1); chk("status_uf_clr", 32'(io_in), 32'h0005);

    // TX fill, overflow and drain
    for (int i = 0; i < 9; i++) begin
      wr(3'd0, 16'hA000 + 16'(i));
      if (i == 0) chk("tx_first_valid", 32'(tx_valid), 32'h1);
    end
    chk("tx_full_head", 32'(tx_data), 32'hA000);
    chk("tx_full_rx_ready", 32'(rx_ready), 32'h1);
    rd(3'd1); chk("status_of", 32'(io_in), 32'h0029);
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("tx_beat_valid", 32'(tx_valid), 32'h1);
      chk("tx_beat_data", 32'(tx_data), 32'hA000 + i);
      step();
    end
    chk("tx_drained", 32'(tx_valid), 32'h0);
    tx_ready = 1'b0;
    rd(3'd1); chk("status_of_clr", 32'(io_in), 32'h0005);

    // RX full, then flush concurrent with a read
    rx_valid = 1'b1;
    rx_data = 16'h00FF;
    for (int i = 0; i < 8; i++) step();
    chk("rx_full_ready", 32'(rx_ready), 32'h0);
    rd(3'd1); chk("status_rx_full", 32'(io_in), 32'h0806);
    rx_valid = 1'b0;
    req_in = 1'b1; addr_in = 3'd0;
    out_en = 1'b1; addr_out = 3'd1; io_out = 16'h0001;
    step();
    req_in = 1'b0; out_en = 1'b0;
    chk("flush_read_data", 32'(io_in), 32'h00FF);
    chk("flush_rx_ready", 32'(rx_ready), 32'h1);
    rd(3'd1); chk("status_flushed", 32'(io_in), 32'h0005);

    // GPO write and GPI synchroniser latency
    gpi[16 +: 16] = 16'h1234;
    wr(3'd3, 16'hBEEF);
    chk("gpo_w1", 32'(gpo[16 +: 16]), 32'hBEEF);
    chk("gpo_w0", 32'(gpo[0 +: 16]), 32'h0);
    step();
    rd(3'd3); chk("gpi_w1", 32'(io_in), 32'h1234);
    gpi[32 +: 16] = 16'h5678;
    rd(3'd4); chk("gpi_sync_e1", 32'(io_in), 32'h0);
    rd(3'd4); chk("gpi_sync_e2", 32'(io_in), 32'h0);
    rd(3'd4); chk("gpi_sync_e3", 32'(io_in), 32'h5678);

    // Asynchronous reset in the middle of a TX burst
    for (int i = 0; i < 4; i++) wr(3'd0, 16'hC000 + 16'(i));
    tx_ready = 1'b1; step();
    tx_ready = 1'b0; step();
    chk("burst_head", 32'(tx_data), 32'hC001);
    tx_ready = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    chk("arst_tx_valid", 32'(tx_valid), 32'h0);
    chk("arst_tx_data", 32'(tx_data), 32'h0);
    chk("arst_gpo", 32'(gpo[16 +: 16]), 32'h0);
    chk("arst_rx_ready", 32'(rx_ready), 32'h0);
    chk("arst_io_in", 32'(io_in), 32'h0);
    tx_ready = 1'b0;
    step();
    rst = 1'b1;
    step();
    rd(3'd1); chk("status_after_arst", 32'(io_in), 32'h0005);
    chk("after_arst_tx_valid", 32'(tx_valid), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/proc_io_bridge.md
Name: proc_io_bridge

Overview:
- Peripheral-side responder for the processor core's IO port.
- Serves processor IO reads (req_in/addr_in/io_in) and IO writes (out_en/addr_out/io_out).
- Bridges both to an external RX stream, an external TX stream, status/control registers and general-purpose input/output words.
- RX and TX each buffer through a FIFO of depth FDEPTH.

Parameters:
- NUBITS, 16: data word width; must be >= 16.
- NUIOIN, 8: number of IO input addresses; must be >= 3.
- NUIOOU, 8: number of IO output addresses; must be >= 3.
- FDEPTH, 8: RX and TX FIFO depth; power of 2, 2..128.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous active-low reset.
- req_in  in  1  processor IO read strobe.
- addr_in  in  $clog2(NUIOIN)  processor IO read address.
- io_in  out  NUBITS  registered read data returned to the processor.
- out_en  in  1  processor IO write strobe.
- addr_out  in  $clog2(NUIOOU)  processor IO write address.
- io_out  in  NUBITS  processor IO write data.
- rx_data  in  NUBITS  external RX word.
- rx_valid  in  1  RX word offered.
- rx_ready  out  1  RX FIFO can accept a word.
- tx_data  out  NUBITS  head of the TX FIFO (show-ahead).
- tx_valid  out  1  TX FIFO not empty.
- tx_ready  in  1  external sink accepts tx_data.
- gpi  in  NUBITS*(NUIOIN-2)  general inputs; word k at [NUBITS*k +: NUBITS].
- gpo  out  NUBITS*(NUIOOU-2)  general output registers, same packing.

Behaviour:
Reset (rst=0, asynchronous):
- Clears both FIFOs, pointers, counts, sticky flags and both gpi sync stages.
- io_in=0, gpo=0, tx_valid=0, tx_data=0, rx_ready=0 while rst=0.
- rx_ready rises the first cycle after release.
- A transfer in progress when reset asserts is discarded; nothing is half-popped or half-pushed.

Read map (on the edge where req_in=1, io_in loads the selected value; the processor samples it one cycle later; io_in holds its value when req_in=0):
- addr 0, RX data: io_in = RX head and pop. If RX is empty, io_in = 0, no pop, and sticky rx_underflow is set.
- addr 1, status:
  - bit0 rx_empty, bit1 rx_full, bit2 tx_empty, bit3 tx_full, bit4 rx_underflow, bit5 tx_overflow.
  - bits[15:8] rx_count, zero-extended.
  - All other bits read 0.
  - The read clears both sticky bits on the same edge. If a new sticky event occurs on that same edge, it wins and the bit stays 1.
- addr k >= 2: io_in = word k-2 of gpi, taken after a 2-flop synchroniser.

Write map (on the edge where out_en=1):
- addr 0, TX push: io_out is pushed into TX. If TX is full (evaluated before any same-cycle pop), the word is dropped and sticky tx_overflow is set.
- addr 1, control: bit0=1 flushes RX, bit1=1 flushes TX. Other bits are ignored; the register is not stored.
- addr k >= 2: gpo word k-2 loads io_out.

FIFOs:
- Circular buffers, read/write pointers of $clog2(FDEPTH) bits, wrap modulo FDEPTH.
- Count of $clog2(FDEPTH)+1 bits, range 0..FDEPTH.
- RX push when rx_valid & rx_ready; rx_ready = !rx_full, registered from the count.
  - A word offered while full is not accepted. The producer holds it (valid/ready rule: rx_data is stable while rx_valid=1 and rx_ready=0).
- TX pop when tx_valid & tx_ready; tx_data changes only after a pop, a push into an empty FIFO, or a flush.
- Simultaneous push and pop on a non-empty, non-full FIFO: count unchanged, both pointers advance.
- Push to an empty FIFO: the word is not poppable that same cycle; it is visible on tx_valid / RX head the next cycle.
- Flush has priority over push and pop on the same edge: count=0, pointers=0, and any same-cycle push is discarded.
- Simultaneous req_in and out_en are independent and both execute.

Test Plan:
- Reset release, then read addr 1 -> io_in = 0x0005 (rx_empty, tx_empty); rx_ready=1; gpo=0; tx_valid=0.
- Stream RX 0x1111, 0x2222, 0x3333, then three reads of addr 0 -> io_in = 0x1111, 0x2222, 0x3333 on consecutive samples. A fourth read returns 0 and status reads 0x0015. The next status read returns 0x0005.
- Write addr 0 with 0xA000+i for i=0..8, holding tx_ready=0 -> after 8 pushes tx_full=1, rx_ready unaffected. The 9th push is dropped. Status reads 0x0029, i.e. bits 0, 3, 5, rx_count=0 (tx_empty bit2 is 0 because TX is full). Then tx_ready=1 -> 8 beats 0xA000..0xA007 in order, then tx_valid=0.
- Fill RX to 8 with rx_valid held at word 0x00FF -> rx_ready=0 and status bits[15:8]=8, bit1=1. On the same edge, write addr 1 = 0x0001 while reading addr 0 -> RX empties; the next status reads rx_count=0.
- Write addr 3 = 0xBEEF and drive gpi word 1 = 0x1234 -> gpo word 1 = 0xBEEF after one edge. A read of addr 3 returns 0x1234 once 2 sync cycles have elapsed.
- Assert rst mid-burst (TX holding 4 words, tx_ready toggling) -> tx_valid=0 and gpo=0 immediately, without waiting for a clock edge. After release, status reads 0x0005.
